// File: rtl/mgmt_pkg.sv
// mgmt_pkg: definitions shared by both ends of the 16-bit-opcode management UART protocol.
//   opcode_t       - known management opcodes
//   MGMT_OP_COUNT  - number of defined opcodes
//   mgmt_reply_len - expected reply length in bytes for an opcode (unknown opcodes -> 0)
//   state_t        - initiator transaction FSM states
package mgmt_pkg;

    typedef enum logic [15:0] {
        OpNop        = 16'h0000,
        OpEcho       = 16'h0001,
        OpDeviceId   = 16'h0002,
        OpFpgaSerial = 16'h0003,
        OpDieTemp    = 16'h0004,
        OpVccInt     = 16'h0005,
        OpVccAux     = 16'h0006,
        OpVccBram    = 16'h0007,
        OpFanSpeed   = 16'h0008
    } opcode_t;

    localparam int unsigned MGMT_OP_COUNT = 9;

    typedef enum logic [2:0] {
        StIdle,
        StTxLo,
        StWaitLo,
        StTxHi,
        StWaitHi,
        StRx,
        StDone
    } state_t;

    function automatic logic [3:0] mgmt_reply_len(opcode_t op);
        logic [3:0] len;
        case (op)
            OpNop:        len = 4'd0;
            OpEcho:       len = 4'd1;
            OpDeviceId:   len = 4'd4;
            OpFpgaSerial: len = 4'd8;
            OpDieTemp,
            OpVccInt,
            OpVccAux,
            OpVccBram,
            OpFanSpeed:   len = 4'd2;
            default:      len = 4'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mgmt_watchdog.sv
// mgmt_watchdog: 16-bit inactivity counter.
//   clk, rst - clock, asynchronous active-high reset
//   clr_i    - synchronous clear (activity seen or engine idle)
//   en_i     - count enable
//   tc_o     - terminal count reached (count == TIMEOUT) while enabled and not being cleared
module mgmt_watchdog #(
    parameter logic [15:0] TIMEOUT = 16'hffff
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'd0;
        end else if (en_i && (cnt_q != TIMEOUT)) begin
            // Saturate at TIMEOUT so the terminal count cannot wrap past zero.
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Activity in the terminal cycle wins over the timeout.
    assign tc_o = en_i && !clr_i && (cnt_q == TIMEOUT);

endmodule

// File: rtl/mgmt_cmd_initiator.sv
// mgmt_cmd_initiator: host side of the management UART protocol. Sends a 16-bit opcode
// little-endian over a byte UART, collects the opcode-dependent reply, reports done/timeout.
//   clk, rst                 - clock, asynchronous active-high reset
//   cmd_en, cmd_opcode       - one-cycle request strobe and opcode (sampled when cmd_busy=0)
//   cmd_busy                 - transaction in flight (through the rsp_valid cycle)
//   uart_tx_data, uart_tx_en - byte and one-cycle strobe to the PHY
//   uart_tx_done             - PHY finished the current byte
//   uart_rx_data, uart_rx_en - received byte and its one-cycle valid
//   rsp_valid                - one-cycle completion pulse
//   rsp_data, rsp_len        - reply bytes (little-endian) and count received
//   rsp_timeout              - completion was a watchdog abort
module mgmt_cmd_initiator
    import mgmt_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'hffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_en,
    input  logic [15:0] cmd_opcode,
    output logic        cmd_busy,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_en,
    input  logic        uart_tx_done,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_en,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic [3:0]  rsp_len,
    output logic        rsp_timeout
);

    state_t      state_q, state_d;
    logic [15:0] opcode_q, opcode_d;
    logic [3:0]  exp_len_q, exp_len_d;
    logic [3:0]  count_q, count_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_len_q, rsp_len_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic accept;
    logic rx_take;
    logic wd_clr;
    logic wd_en;
    logic wd_tc;

    assign wd_en  = (state_q != StIdle);
    assign wd_clr = (state_q == StIdle) || uart_tx_done || uart_rx_en;

    mgmt_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk  (clk),
        .rst  (rst),
        .clr_i(wd_clr),
        .en_i (wd_en),
        .tc_o (wd_tc)
    );

    // The completion pulse cycle still counts as busy, so a new command is taken one cycle later.
    assign accept = (state_q == StIdle) && !rsp_valid_q && cmd_en;

    // Replies may start before the local high-byte done, so WAIT_HI captures as well as RX.
    assign rx_take = uart_rx_en && ((state_q == StWaitHi) || (state_q == StRx)) &&
                     (count_q < exp_len_q);

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        exp_len_d     = exp_len_q;
        count_d       = count_q;
        rsp_data_d    = rsp_data_q;
        rsp_len_d     = rsp_len_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_valid_d   = 1'b0;
        tx_en_d       = 1'b0;
        tx_data_d     = tx_data_q;

        if (rx_take) begin
            rsp_data_d[{count_q[2:0], 3'b000} +: 8] = uart_rx_data;
            count_d                                 = count_q + 4'd1;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    opcode_d      = cmd_opcode;
                    exp_len_d     = mgmt_reply_len(opcode_t'(cmd_opcode));
                    count_d       = 4'd0;
                    rsp_data_d    = 64'd0;
                    rsp_len_d     = 4'd0;
                    rsp_timeout_d = 1'b0;
                    // Low byte is issued on accept so its strobe lands in the TX_LO cycle.
                    tx_en_d       = 1'b1;
                    tx_data_d     = cmd_opcode[7:0];
                    state_d       = StTxLo;
                end
            end
            StTxLo: begin
                state_d = uart_tx_done ? StTxHi : StWaitLo;
            end
            StWaitLo: begin
                if (uart_tx_done) begin
                    state_d = StTxHi;
                end
            end
            StTxHi: begin
                tx_en_d   = 1'b1;
                tx_data_d = opcode_q[15:8];
                state_d   = StWaitHi;
            end
            StWaitHi: begin
                if (uart_tx_done) begin
                    state_d = (count_d == exp_len_q) ? StDone : StRx;
                end
            end
            StRx: begin
                if (count_d == exp_len_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                rsp_valid_d   = 1'b1;
                rsp_len_d     = count_q;
                rsp_timeout_d = 1'b0;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (wd_tc && (state_q != StDone)) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_len_d     = count_q;
            tx_en_d       = 1'b0;
            state_d       = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            opcode_q      <= 16'd0;
            exp_len_q     <= 4'd0;
            count_q       <= 4'd0;
            rsp_data_q    <= 64'd0;
            rsp_len_q     <= 4'd0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            tx_en_q       <= 1'b0;
            tx_data_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            exp_len_q     <= exp_len_d;
            count_q       <= count_d;
            rsp_data_q    <= rsp_data_d;
            rsp_len_q     <= rsp_len_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_valid_q   <= rsp_valid_d;
            tx_en_q       <= tx_en_d;
            tx_data_q     <= tx_data_d;
        end
    end

    assign cmd_busy     = (state_q != StIdle) || rsp_valid_q;
    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_len      = rsp_len_q;
    assign rsp_timeout  = rsp_timeout_q;

endmodule

// File: doc/mgmt_cmd_initiator.md
# mgmt_cmd_initiator

Host-side end of the 16-bit-opcode management UART protocol. It accepts one command request per transaction and sends the opcode little-endian over a byte-wide UART transmit interface. It then collects the opcode-dependent number of reply bytes into a response register and reports completion or timeout. It sits in front of a UART PHY, either in a bench/loopback design driving the management controller or in a peer FPGA managing this one.

## Interface
Parameters:
- TIMEOUT, 16'hffff: idle cycles without transmit completion or receive activity before the transaction aborts.

Ports:
- clk  in  1  management engine clock; all logic in this single domain.
- rst  in  1  reset, asynchronous and active-high.
- cmd_en  in  1  one-cycle request strobe; sampled only when cmd_busy=0.
- cmd_opcode  in  16  opcode to send.
- cmd_busy  out  1  high from the cycle after an accepted cmd_en through the cycle rsp_valid is asserted.
- uart_tx_data  out  8  byte to transmit.
- uart_tx_en  out  1  one-cycle transmit strobe.
- uart_tx_done  in  1  PHY finished the current byte.
- uart_rx_data  in  8  received byte.
- uart_rx_en  in  1  received byte valid, one cycle.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  64  reply bytes, little-endian; byte k in bits [8k+7:8k]; unreceived bytes are 0.
- rsp_len  out  4  number of bytes actually received (0–8).
- rsp_timeout  out  1  qualifies rsp_valid: transaction aborted by watchdog.

## Operation
- Reset values: all outputs 0, state IDLE, byte counter 0, watchdog 0.
- Expected reply length comes from a package function of the opcode:
  - NOP 0x0000 → 0; ECHO 0x0001 → 1; DEVICE_ID 0x0002 → 4; FPGA_SERIAL 0x0003 → 8; 0x0004–0x0008 → 2.
  - Any other opcode → 0.
- States:
  - IDLE: on cmd_en, latch the opcode and expected length, clear rsp_data, go to TX_LO. Ignore uart_rx_en here (stray bytes are dropped).
  - TX_LO: pulse uart_tx_en with opcode[7:0], go to WAIT_LO.
  - WAIT_LO: on uart_tx_done, go to TX_HI.
  - TX_HI: pulse uart_tx_en with opcode[15:8], go to WAIT_HI.
  - WAIT_HI: on uart_tx_done, go to RX, or to DONE if the expected length is 0. Capture reply bytes arriving in this state, because the responder may answer before the local done.
  - RX: on each uart_rx_en, store the byte at index count and increment count. When count reaches the expected length, go to DONE.
  - DONE: pulse rsp_valid, load rsp_len=count and rsp_timeout=0, return to IDLE.
- Watchdog:
  - Cleared in IDLE and on every uart_tx_done or uart_rx_en.
  - Otherwise increments in every non-IDLE state.
  - At TIMEOUT: pulse rsp_valid with rsp_timeout=1 and rsp_len=count, return to IDLE. The partial rsp_data is retained.
- Extra uart_rx_en after the expected length is reached is ignored.
- cmd_en while busy is ignored; there is no queueing.
- rst mid-transaction aborts immediately to reset values with no rsp_valid. A byte already strobed to the PHY may still go out on the wire.

## Timing
- cmd_en at cycle 0 → uart_tx_en with the low byte at cycle 1; cmd_busy high from cycle 1.
- uart_tx_done at cycle n (WAIT_LO) → high-byte uart_tx_en at cycle n+2.
- Receive: a byte is captured in the same cycle uart_rx_en is high.
- Last reply byte at cycle m → rsp_valid at m+2. For zero-length opcodes, rsp_valid follows the high-byte uart_tx_done by 2 cycles.
- Simultaneous uart_tx_done and uart_rx_en in WAIT_HI: both take effect.
- rsp_data, rsp_len and rsp_timeout hold their values until the next accepted cmd_en.
- Back-to-back: a new cmd_en is accepted the cycle after rsp_valid.

## Structure
- Shared package mgmt_pkg holds:
  - opcode_t enum (values above);
  - MGMT_OP_COUNT;
  - function mgmt_reply_len(opcode_t) returning logic[3:0].
- The responder side imports the same package so the two ends cannot drift.
- One sub-module: mgmt_watchdog (16-bit counter with clear, enable and terminal-count output, parameter TIMEOUT).

## Test plan
- DEVICE_ID: cmd_opcode=0x0002; a model PHY answers 0x78 0x56 0x34 0x12 → tx bytes 0x02,0x00; rsp_data=0x12345678; rsp_len=4; rsp_timeout=0.
- FPGA_SERIAL with the first reply byte arriving in the same cycle as the high-byte uart_tx_done → all 8 bytes captured in order; rsp_len=8.
- NOP 0x0000 and unknown opcode 0x1234 → exactly two tx bytes, then rsp_valid with rsp_len=0, without waiting for rx.
- DIE_TEMP with only 1 reply byte 0xAB and TIMEOUT=16 → after 16 idle cycles, rsp_valid with rsp_timeout=1, rsp_len=1, rsp_data=0xAB.
- cmd_en pulsed while busy, plus stray uart_rx_en in IDLE → no extra transaction, no corruption of the next reply.
- rst asserted during WAIT_HI → all outputs 0 asynchronously; no rsp_valid; the next ECHO returns 0x55 normally.
